dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/debug loader (DMA). The arbiter grants at most one access per cycle and gives the CPU priority, with a starvation guard for DMA. It checks alignment and range, converts byte addresses to word indices, and returns a registered response one cycle after each grant. It sits between the MEM stage / DMA engine and the data memory array.

## Interface
- DATA_W, 32, data word width
- DEPTH, 1024, memory depth in words; MEM_AW = $clog2(DEPTH)
- STARVE_LIMIT, 4, number of contested cycles DMA loses before it is forced a win (≥1)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req_valid  in  1  CPU access request
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  DATA_W  write data
- cpu_req_ready  out  1  grant this cycle; low = MEM-stage stall
- cpu_rsp_valid  out  1  response for the access granted last cycle
- cpu_rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- cpu_rsp_err  out  1  misaligned or out-of-range access
- dma_req_valid, dma_req_we, dma_req_addr, dma_req_wdata, dma_req_ready, dma_rsp_valid, dma_rsp_rdata, dma_rsp_err  same directions, widths and meanings as the CPU set
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_AW  word index
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- Arbitration state has two values: CPU_PRI (the reset value) and DMA_PRI.
- **Only one requester valid:** that requester is granted.
- **Both requesters valid:**
  - In CPU_PRI, the CPU wins.
  - In DMA_PRI, DMA wins, and the state returns to CPU_PRI on the next edge.
- **Starvation counter (0..STARVE_LIMIT):**
  - Increments on each cycle in which DMA is valid and not granted.
  - Clears to 0 when DMA is granted or dma_req_valid = 0.
  - When it reaches STARVE_LIMIT, the state becomes DMA_PRI on the next edge.
- **Ready signals:** `*_req_ready` equals the grant and is combinational from the current valids and state. Both readies are forced to 0 while rst_n = 0.
- **Access check** on the granted request:
  - err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - mem_addr = addr[MEM_AW+1:2].
  - mem_we = grant & we & ~err & rst_n.
  - mem_wdata = granted wdata.
  - With no grant, mem_we = 0, and mem_addr/mem_wdata hold the CPU request fields.
- **Response register:**
  - On a grant edge, the granted side's rsp_valid is set to 1 for exactly one cycle.
  - rdata is captured from mem_rdata for a valid read; it is 0 for a write or an error.
  - err is captured from the check.
  - The non-granted side's rsp_valid is 0.
- **Write responses:** a write also produces a response (acknowledge). An erroring write never reaches the memory.
- **Reset values:** state CPU_PRI, counter 0, both rsp_valid 0, both rsp_rdata 0, both rsp_err 0.
- **Reset mid-operation:** a response pending for the next cycle is dropped. No write is issued in any cycle where rst_n = 0.

## Timing
- **Request-to-response latency:** 1 cycle (grant at edge N; response valid during cycle N+1).
- **Throughput:** 1 access per cycle in total.
- **Back-to-back grants** to the same requester are allowed. rsp_valid then stays high on consecutive cycles, with new data each cycle.
- **Read data:** mem_rdata is sampled in the grant cycle (combinational-read array). Read-after-write to the same word in the next cycle returns the new data.
- **Worst-case DMA wait** under continuous CPU traffic: STARVE_LIMIT + 1 cycles from first valid to grant.
- **Request stability:** requesters must hold valid and fields stable until ready.

## Structure
- **Package dmem_arb_pkg:**
  - mem_req_t struct (valid, we, addr, wdata)
  - mem_rsp_t struct (valid, rdata, err)
  - arb_state_e enum (CPU_PRI, DMA_PRI)
  - constant WORD_OFFSET = 2
- **Sub-module dmem_addr_check:** combinational alignment/range check and word-index conversion. It is parameterised by DEPTH and instantiated once, on the granted request after the grant mux.

## Test plan
- **Reset:**
  - Stimulus: hold rst_n = 0 for 3 cycles with both valids high.
  - Required: both readies 0, mem_we 0, all rsp outputs 0, state CPU_PRI.
- **CPU write then read:**
  - Stimulus: CPU writes 0xDEADBEEF to addr 0x10, then reads addr 0x10.
  - Required: mem_addr = 4 with mem_we = 1; next-cycle ack rsp_valid = 1 with rdata 0; the read response returns 0xDEADBEEF one cycle after its grant.
- **Starvation:**
  - Stimulus: CPU and DMA both valid continuously, STARVE_LIMIT = 4.
  - Required: CPU granted 4 cycles, DMA granted on the 5th, CPU on the 6th; the pattern repeats with period 5.
- **Errors:**
  - Stimulus 1: CPU writes addr 0x6. Required: mem_we = 0, cpu_rsp_err = 1, memory word 1 unchanged.
  - Stimulus 2: DMA reads addr 0x1000 (word index 1024). Required: dma_rsp_err = 1, rdata 0.
- **Reset mid-operation:**
  - Stimulus: DMA read granted at edge N, then rst_n = 0 during cycle N+1.
  - Required: dma_rsp_valid cleared at edge N+1, counter 0, no spurious response after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
  localparam int WORD_OFFSET = 2;
  localparam int PKG_DATA_W = 32;
  typedef enum logic {CPU_PRI, DMA_PRI} arb_state_e;
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [31:0]           addr;
    logic [PKG_DATA_W-1:0] wdata;
  } mem_req_t;
  typedef struct packed {
    logic                  valid;
    logic [PKG_DATA_W-1:0] rdata;
    logic                  err;
  } mem_rsp_t;
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: alignment/range check and byte-to-word index conversion
module dmem_addr_check
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int MEM_AW = $clog2(DEPTH)
) (
  input  logic [31:0]       addr,
  output logic              err,
  output logic [MEM_AW-1:0] idx
);
  assign err = (addr[WORD_OFFSET-1:0] != '0) || ((addr >> WORD_OFFSET) >= 32'(DEPTH));
  assign idx = addr[MEM_AW+WORD_OFFSET-1:WORD_OFFSET];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority data-memory arbiter with DMA starvation guard
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [31:0]       cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,
  input  logic              dma_req_valid,
  input  logic              dma_req_we,
  input  logic [31:0]       dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ready,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_rdata,
  output logic              dma_rsp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  arb_state_e        state, state_nxt;
  logic [CW-1:0]     starve, starve_nxt;
  logic              cpu_gnt, dma_gnt, g_we, err;
  logic [31:0]       g_addr;
  logic [DATA_W-1:0] rsp_rdata;
  dmem_addr_check #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) u_check (
    .addr(g_addr),
    .err (err),
    .idx (mem_addr)
  );
  // The mux defaults to the CPU fields so an idle cycle still presents them.
  always_comb begin
    cpu_gnt    = rst_n && cpu_req_valid && !(dma_req_valid && state == DMA_PRI);
    dma_gnt    = rst_n && dma_req_valid && (!cpu_req_valid || state == DMA_PRI);
    g_addr     = dma_gnt ? dma_req_addr : cpu_req_addr;
    g_we       = dma_gnt ? dma_req_we : cpu_req_we;
    mem_wdata  = dma_gnt ? dma_req_wdata : cpu_req_wdata;
    mem_we     = (cpu_gnt || dma_gnt) && g_we && !err;
    rsp_rdata  = (g_we || err) ? '0 : mem_rdata;
    starve_nxt = (dma_req_valid && !dma_gnt) ? starve + CW'(1) : '0;
    state_nxt  = dma_gnt ? CPU_PRI : (starve_nxt == CW'(STARVE_LIMIT) ? DMA_PRI : state);
  end
  assign cpu_req_ready = cpu_gnt;
  assign dma_req_ready = dma_gnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= CPU_PRI;
      starve        <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      cpu_rsp_err   <= 1'b0;
      dma_rsp_valid <= 1'b0;
      dma_rsp_rdata <= '0;
      dma_rsp_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      starve        <= starve_nxt;
      cpu_rsp_valid <= cpu_gnt;
      cpu_rsp_rdata <= cpu_gnt ? rsp_rdata : '0;
      cpu_rsp_err   <= cpu_gnt && err;
      dma_rsp_valid <= dma_gnt;
      dma_rsp_rdata <= dma_gnt ? rsp_rdata : '0;
      dma_rsp_err   <= dma_gnt && err;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;
  localparam int DATA_W = 32, DEPTH = 1024, STARVE_LIMIT = 4, MEM_AW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req_valid = 1'b0, cpu_req_we = 1'b0, cpu_req_ready, cpu_rsp_valid, cpu_rsp_err;
  logic [31:0] cpu_req_addr = '0;
  logic [DATA_W-1:0] cpu_req_wdata = '0, cpu_rsp_rdata;
  logic dma_req_valid = 1'b0, dma_req_we = 1'b0, dma_req_ready, dma_rsp_valid, dma_rsp_err;
  logic [31:0] dma_req_addr = '0;
  logic [DATA_W-1:0] dma_req_wdata = '0, dma_rsp_rdata;
  logic mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  int checks = 0, errors = 0, losses = 0;
  logic exp_cpu_v = 1'b0, exp_dma_v = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ready(dma_req_ready), .dma_rsp_valid(dma_rsp_valid),
    .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b0) || ((a >> 2) >= 32'(DEPTH));
  endfunction
  // DMA wins when alone, or once it has lost STARVE_LIMIT contested cycles in a row.
  function automatic logic m_dma_gnt();
    return rst_n && dma_req_valid && (!cpu_req_valid || losses == STARVE_LIMIT);
  endfunction
  function automatic logic m_cpu_gnt();
    return rst_n && cpu_req_valid && !m_dma_gnt();
  endfunction

  task automatic model_edge();
    logic cg, dg, we, e;
    logic [31:0] a, wd;
    dg = m_dma_gnt();
    cg = m_cpu_gnt();
    a  = dg ? dma_req_addr : cpu_req_addr;
    we = dg ? dma_req_we : cpu_req_we;
    wd = dg ? dma_req_wdata : cpu_req_wdata;
    e  = bad(a);
    exp_cpu_v = cg;
    exp_dma_v = dg;
    exp_err   = e;
    exp_rdata = (we || e) ? '0 : ref_mem[a[MEM_AW+1:2]];
    if ((cg || dg) && we && !e) ref_mem[a[MEM_AW+1:2]] = wd;
    losses = (rst_n && dma_req_valid && !dg) ? losses + 1 : 0;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic cv, cw, input logic [31:0] ca, cd,
                         input logic dv, dw, input logic [31:0] da, dd);
    cpu_req_valid = cv; cpu_req_we = cw; cpu_req_addr = ca; cpu_req_wdata = cd;
    dma_req_valid = dv; dma_req_we = dw; dma_req_addr = da; dma_req_wdata = dd;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      set_req(1, 1, 32'h8, 32'h1111, 1, 1, 32'hC, 32'h2222);
      #1;
      checks++; if ({cpu_req_ready, dma_req_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL reset ready/we: got %b exp 000", {cpu_req_ready, dma_req_ready, mem_we}); end
      cyc();
      checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata, dma_rsp_valid, dma_rsp_err, dma_rsp_rdata} !== '0) begin errors++; $display("FAIL reset rsp: cpu v%b e%b d%h dma v%b e%b d%h exp all 0", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata, dma_rsp_valid, dma_rsp_err, dma_rsp_rdata); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
    #1;
    checks++; if ({cpu_req_ready, dma_req_ready} !== 2'b10) begin errors++; $display("FAIL reset state cpu-priority: got %b exp 10", {cpu_req_ready, dma_req_ready}); end
    cyc();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_req(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    checks++; if ({cpu_req_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd4, 32'hDEADBEEF}) begin errors++; $display("FAIL wr issue: rdy %b we %b addr %0d wd %h exp 1 1 4 deadbeef", cpu_req_ready, mem_we, mem_addr, mem_wdata); end
    cyc();
    checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wr ack: v%b e%b d%h exp v1 e0 d0", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
    @(negedge clk);
    set_req(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    checks++; if ({cpu_req_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd4}) begin errors++; $display("FAIL rd issue: rdy %b we %b addr %0d exp 1 0 4", cpu_req_ready, mem_we, mem_addr); end
    cyc();
    checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL rd rsp: v%b e%b d%h exp v1 e0 deadbeef", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== 2'b00) begin errors++; $display("FAIL idle rsp: got %b exp 00", {cpu_rsp_valid, dma_rsp_valid}); end
  endtask

  task automatic test_errors();
    logic [31:0] w1;
    w1 = ref_mem[1];
    @(negedge clk);
    set_req(1, 1, 32'h6, 32'h12345678, 0, 0, 0, 0);
    #1;
    checks++; if ({cpu_req_ready, mem_we} !== 2'b10) begin errors++; $display("FAIL misaligned wr: rdy/we %b exp 10", {cpu_req_ready, mem_we}); end
    cyc();
    checks++; if ({cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL misaligned rsp: v%b e%b d%h exp v1 e1 d0", cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata); end
    @(negedge clk);
    set_req(1, 0, 32'h4, 0, 0, 0, 0, 0);
    cyc();
    checks++; if (cpu_rsp_rdata !== w1) begin errors++; $display("FAIL word1 after bad wr: got %h exp %h", cpu_rsp_rdata, w1); end
    @(negedge clk);
    set_req(0, 0, 0, 0, 1, 0, 32'h1000, 0);
    #1;
    checks++; if ({cpu_req_ready, dma_req_ready} !== 2'b01) begin errors++; $display("FAIL dma oor grant: got %b exp 01", {cpu_req_ready, dma_req_ready}); end
    cyc();
    checks++; if ({dma_rsp_valid, dma_rsp_err, dma_rsp_rdata, cpu_rsp_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL dma oor rsp: v%b e%b d%h cpu_v%b exp v1 e1 d0 cpu_v0", dma_rsp_valid, dma_rsp_err, dma_rsp_rdata, cpu_rsp_valid); end
  endtask

  task automatic test_starvation();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      set_req(1, 0, 32'h20, 0, 1, 0, 32'h24, 0);
      #1;
      checks++; if ({cpu_req_ready, dma_req_ready} !== {k % 5 != 0, k % 5 == 0}) begin errors++; $display("FAIL starve cycle %0d: cpu/dma rdy %b exp %b", k, {cpu_req_ready, dma_req_ready}, {k % 5 != 0, k % 5 == 0}); end
      cyc();
    end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_req(1, i < 4, 32'h40 + 32'(4 * (i % 4)), 32'h11111111 * 32'(i + 1), 0, 0, 0, 0);
      cyc();
      checks++; if ({cpu_rsp_valid, cpu_rsp_rdata} !== {1'b1, exp_rdata}) begin errors++; $display("FAIL b2b %0d: v%b d%h exp v1 d%h", i, cpu_rsp_valid, cpu_rsp_rdata, exp_rdata); end
      if (i >= 4) begin
        checks++; if (cpu_rsp_rdata !== 32'h11111111 * 32'(i - 3)) begin errors++; $display("FAIL b2b data %0d: got %h exp %h", i, cpu_rsp_rdata, 32'h11111111 * 32'(i - 3)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({cpu_req_ready, dma_req_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL mid reset ready/we: got %b exp 000", {cpu_req_ready, dma_req_ready, mem_we}); end
      cyc();
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (dma_req_ready !== (k == 5)) begin errors++; $display("FAIL counter cleared by reset, cycle %0d: dma rdy %b exp %b", k, dma_req_ready, k == 5); end
      cyc();
    end
    @(negedge clk);
    set_req(0, 0, 0, 0, 1, 0, 32'h10, 0);
    cyc();
    checks++; if ({dma_rsp_valid, dma_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL mid dma rsp: v%b d%h exp v1 deadbeef", dma_rsp_valid, dma_rsp_rdata); end
    @(negedge clk);
    rst_n = 1'b0;
    set_req(1, 1, 32'h18, 32'hBAD0BAD0, 1, 0, 32'h14, 0);
    #1;
    checks++; if ({cpu_req_ready, dma_req_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL mid reset write blocked: got %b exp 000", {cpu_req_ready, dma_req_ready, mem_we}); end
    cyc();
    checks++; if ({dma_rsp_valid, dma_rsp_rdata, cpu_rsp_valid} !== '0) begin errors++; $display("FAIL mid reset drop: dma v%b d%h cpu v%b exp 0", dma_rsp_valid, dma_rsp_rdata, cpu_rsp_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== 2'b00) begin errors++; $display("FAIL spurious rsp after reset: got %b exp 00", {cpu_rsp_valid, dma_rsp_valid}); end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (r == 1) return 32'h1000 + 32'(4 * $urandom_range(0, 40));
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic test_random();
    mem_req_t cp, dp;
    logic cg, dg, we;
    logic [31:0] a, wd;
    cp = '0;
    dp = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!cp.valid && $urandom_range(0, 9) < 7) cp = '{1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom};
      if (!dp.valid && $urandom_range(0, 9) < 5) dp = '{1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom};
      rst_n = ($urandom_range(0, 49) != 0);
      set_req(cp.valid, cp.we, cp.addr, cp.wdata, dp.valid, dp.we, dp.addr, dp.wdata);
      #1;
      dg = m_dma_gnt();
      cg = m_cpu_gnt();
      a  = dg ? dp.addr : cp.addr;
      we = dg ? dp.we : cp.we;
      wd = dg ? dp.wdata : cp.wdata;
      checks++; if ({cpu_req_ready, dma_req_ready} !== {cg, dg}) begin errors++; $display("FAIL rand %0d ready: got %b exp %b", n, {cpu_req_ready, dma_req_ready}, {cg, dg}); end
      checks++; if (mem_we !== ((cg || dg) && we && !bad(a))) begin errors++; $display("FAIL rand %0d mem_we: got %b exp %b", n, mem_we, (cg || dg) && we && !bad(a)); end
      if (cg || dg) begin
        checks++; if (mem_addr !== a[MEM_AW+1:2]) begin errors++; $display("FAIL rand %0d mem_addr: got %0d exp %0d", n, mem_addr, a[MEM_AW+1:2]); end
        checks++; if (mem_wdata !== wd) begin errors++; $display("FAIL rand %0d mem_wdata: got %h exp %h", n, mem_wdata, wd); end
      end
      cyc();
      checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== {exp_cpu_v, exp_dma_v}) begin errors++; $display("FAIL rand %0d rsp_valid: got %b exp %b", n, {cpu_rsp_valid, dma_rsp_valid}, {exp_cpu_v, exp_dma_v}); end
      if (exp_cpu_v) begin
        checks++; if ({cpu_rsp_err, cpu_rsp_rdata} !== {exp_err, exp_rdata}) begin errors++; $display("FAIL rand %0d cpu rsp: e%b d%h exp e%b d%h", n, cpu_rsp_err, cpu_rsp_rdata, exp_err, exp_rdata); end
        cp.valid = 1'b0;
      end
      if (exp_dma_v) begin
        checks++; if ({dma_rsp_err, dma_rsp_rdata} !== {exp_err, exp_rdata}) begin errors++; $display("FAIL rand %0d dma rsp: e%b d%h exp e%b d%h", n, dma_rsp_err, dma_rsp_rdata, exp_err, exp_rdata); end
        dp.valid = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
